// File: rtl/lcd_fill_rect_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_fill_rect_ctrl
//   Paints a solid RGB565 rectangle on the ST7735 panel. On an accepted start
//   it sends CASET/RASET/RAMWR (11 header bytes) and then streams the pixel
//   colour bytes through the shared lcd_write byte engine. Each byte is
//   handed over with a one-cycle en_write_fill pulse and closed by wr_done.
//
// Ports
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   init_done            panel initialised; start ignored while low
//   start                one-cycle request, sampled only in IDLE
//   start_x/start_y      top-left corner (inclusive)
//   end_x/end_y          bottom-right corner (inclusive)
//   color                RGB565 fill colour
//   wr_done              byte shifted out by lcd_write
//   fill_data            {D/C, byte} to lcd_write, held until wr_done
//   en_write_fill        one-cycle byte request
//   busy                 request in progress
//   fill_done            one-cycle completion pulse
//   fill_err             one-cycle pulse with fill_done on a rejected request
// ---------------------------------------------------------------------------
module lcd_fill_rect_ctrl #(
    parameter int unsigned LCD_W    = 128,
    parameter int unsigned LCD_H    = 160,
    parameter int unsigned X_OFFSET = 0,
    parameter int unsigned Y_OFFSET = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_done,
    input  logic        start,
    input  logic [8:0]  start_x,
    input  logic [8:0]  start_y,
    input  logic [8:0]  end_x,
    input  logic [8:0]  end_y,
    input  logic [15:0] color,
    input  logic        wr_done,
    output logic [8:0]  fill_data,
    output logic        en_write_fill,
    output logic        busy,
    output logic        fill_done,
    output logic        fill_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [8:0]  sx_q, sy_q, ex_q, ey_q;
    logic [15:0] color_q;
    logic [3:0]  hdr_idx_q;
    logic        pix_phase_q;   // 0: header bytes, 1: pixel bytes
    logic        lo_q;          // byte in flight is the colour low byte
    logic [16:0] pix_left_q;    // pixels remaining, including the one in flight
    logic [8:0]  data_q;
    logic        en_q, busy_q, done_q, err_q;

    // Panel-space coordinates (glass offset applied), 16-bit as transmitted
    logic [15:0] xs, xe, ys, ye;
    assign xs = 16'(sx_q) + 16'(X_OFFSET);
    assign xe = 16'(ex_q) + 16'(X_OFFSET);
    assign ys = 16'(sy_q) + 16'(Y_OFFSET);
    assign ye = 16'(ey_q) + 16'(Y_OFFSET);

    logic        reject_d;
    logic [9:0]  width_d, height_d;
    logic [16:0] pix_total_d;
    logic [8:0]  hdr_next_d;

    function automatic logic [8:0] hdr_byte(input logic [3:0]  idx,
                                            input logic [15:0] x0,
                                            input logic [15:0] x1,
                                            input logic [15:0] y0,
                                            input logic [15:0] y1);
        logic [8:0] b;
        case (idx)
            4'd0:    b = 9'h02A;
            4'd1:    b = {1'b1, x0[15:8]};
            4'd2:    b = {1'b1, x0[7:0]};
            4'd3:    b = {1'b1, x1[15:8]};
            4'd4:    b = {1'b1, x1[7:0]};
            4'd5:    b = 9'h02B;
            4'd6:    b = {1'b1, y0[15:8]};
            4'd7:    b = {1'b1, y0[7:0]};
            4'd8:    b = {1'b1, y1[15:8]};
            4'd9:    b = {1'b1, y1[7:0]};
            default: b = 9'h02C;
        endcase
        return b;
    endfunction

    always_comb begin
        reject_d    = (ex_q < sx_q) || (ey_q < sy_q) ||
                      (32'(ex_q) >= LCD_W) || (32'(ey_q) >= LCD_H);
        width_d     = {1'b0, ex_q} - {1'b0, sx_q} + 10'd1;
        height_d    = {1'b0, ey_q} - {1'b0, sy_q} + 10'd1;
        pix_total_d = 17'(width_d) * 17'(height_d);
        hdr_next_d  = hdr_byte(hdr_idx_q + 4'd1, xs, xe, ys, ye);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            sx_q        <= '0;
            sy_q        <= '0;
            ex_q        <= '0;
            ey_q        <= '0;
            color_q     <= '0;
            hdr_idx_q   <= '0;
            pix_phase_q <= 1'b0;
            lo_q        <= 1'b0;
            pix_left_q  <= '0;
            data_q      <= '0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && init_done) begin
                        sx_q    <= start_x;
                        sy_q    <= start_y;
                        ex_q    <= end_x;
                        ey_q    <= end_y;
                        color_q <= color;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (reject_d) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        // First byte is issued on the way into SEND so the
                        // registered strobe is visible in the SEND cycle.
                        hdr_idx_q   <= '0;
                        pix_phase_q <= 1'b0;
                        lo_q        <= 1'b0;
                        pix_left_q  <= pix_total_d;
                        data_q      <= 9'h02A;
                        en_q        <= 1'b1;
                        state_q     <= S_SEND;
                    end
                end
                S_SEND: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (wr_done) begin
                        if (!pix_phase_q) begin
                            if (hdr_idx_q == 4'd10) begin
                                pix_phase_q <= 1'b1;
                                lo_q        <= 1'b0;
                                data_q      <= {1'b1, color_q[15:8]};
                            end else begin
                                hdr_idx_q <= hdr_idx_q + 4'd1;
                                data_q    <= hdr_next_d;
                            end
                            en_q    <= 1'b1;
                            state_q <= S_SEND;
                        end else if (!lo_q) begin
                            lo_q    <= 1'b1;
                            data_q  <= {1'b1, color_q[7:0]};
                            en_q    <= 1'b1;
                            state_q <= S_SEND;
                        end else if (pix_left_q == 17'd1) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            pix_left_q <= pix_left_q - 17'd1;
                            lo_q       <= 1'b0;
                            data_q     <= {1'b1, color_q[15:8]};
                            en_q       <= 1'b1;
                            state_q    <= S_SEND;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fill_data     = data_q;
    assign en_write_fill = en_q;
    assign busy          = busy_q;
    assign fill_done     = done_q;
    assign fill_err      = err_q;

endmodule

// File: tb/tb_lcd_fill_rect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_fill_rect_ctrl
//   Directed and randomised fills against a reference byte list built from
//   the rectangle arithmetic. The bench plays the lcd_write engine, answering
//   each byte with wr_done after a chosen latency.
// ---------------------------------------------------------------------------
module tb_lcd_fill_rect_ctrl;

    localparam int unsigned W  = 64;
    localparam int unsigned H  = 80;
    localparam int unsigned XO = 2;
    localparam int unsigned YO = 1;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic        start     = 1'b0;
    logic        wr_done   = 1'b0;
    logic [8:0]  start_x   = '0;
    logic [8:0]  start_y   = '0;
    logic [8:0]  end_x     = '0;
    logic [8:0]  end_y     = '0;
    logic [15:0] color     = '0;
    logic [8:0]  fill_data;
    logic        en_write_fill, busy, fill_done, fill_err;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    lcd_fill_rect_ctrl #(
        .LCD_W   (W),
        .LCD_H   (H),
        .X_OFFSET(XO),
        .Y_OFFSET(YO)
    ) u_dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .init_done    (init_done),
        .start        (start),
        .start_x      (start_x),
        .start_y      (start_y),
        .end_x        (end_x),
        .end_y        (end_y),
        .color        (color),
        .wr_done      (wr_done),
        .fill_data    (fill_data),
        .en_write_fill(en_write_fill),
        .busy         (busy),
        .fill_done    (fill_done),
        .fill_err     (fill_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic recover();
        start     = 1'b0;
        wr_done   = 1'b0;
        sys_rst_n = 1'b0;
        tick();
        tick();
        #2 sys_rst_n = 1'b1;
        tick();
    endtask

    // One request: poke injects a stray wr_done in SEND and a start while busy;
    // abort_at >= 0 asserts reset while that byte is being presented.
    task automatic do_fill(input int unsigned sx, input int unsigned sy,
                           input int unsigned ex, input int unsigned ey,
                           input logic [15:0] col, input int unsigned lat,
                           input bit poke, input int abort_at);
        logic [8:0]  exp_q[$];
        logic [15:0] xs, xe, ys, ye;
        int unsigned n;
        bit          bad, stab;
        int          e0;
        e0  = errors;
        bad = (ex < sx) || (ey < sy) || (ex >= W) || (ey >= H);
        if (!bad) begin
            xs = 16'(sx + XO);
            xe = 16'(ex + XO);
            ys = 16'(sy + YO);
            ye = 16'(ey + YO);
            exp_q.push_back(9'h02A);
            exp_q.push_back({1'b1, xs[15:8]});
            exp_q.push_back({1'b1, xs[7:0]});
            exp_q.push_back({1'b1, xe[15:8]});
            exp_q.push_back({1'b1, xe[7:0]});
            exp_q.push_back(9'h02B);
            exp_q.push_back({1'b1, ys[15:8]});
            exp_q.push_back({1'b1, ys[7:0]});
            exp_q.push_back({1'b1, ye[15:8]});
            exp_q.push_back({1'b1, ye[7:0]});
            exp_q.push_back(9'h02C);
            n = (ex - sx + 1) * (ey - sy + 1);
            for (int unsigned p = 0; p < n; p++) begin
                exp_q.push_back({1'b1, col[15:8]});
                exp_q.push_back({1'b1, col[7:0]});
            end
        end
        start_x = 9'(sx);
        start_y = 9'(sy);
        end_x   = 9'(ex);
        end_y   = 9'(ey);
        color   = col;
        start   = 1'b1;
        tick();                         // cycle T+1
        start   = 1'b0;
        // Inputs are scrambled: the stream must come from the latched request
        start_x = 9'($urandom);
        start_y = 9'($urandom);
        end_x   = 9'($urandom);
        end_y   = 9'($urandom);
        color   = 16'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        tick();                         // cycle T+2
        if (bad) begin
            check("reject_pulse", 32'({fill_done, fill_err, en_write_fill}), 32'b110);
            tick();
            check("reject_idle", 32'({busy, fill_done, fill_err, en_write_fill}), 32'd0);
            if (errors != e0) recover();
            return;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            check("en_timing", 32'(en_write_fill), 32'd1);
            check("byte", 32'(fill_data), 32'(exp_q[i]));
            if (i == abort_at) begin
                #2 sys_rst_n = 1'b0;
                #1;
                check("async_reset_outs",
                      32'({fill_data, en_write_fill, busy, fill_done, fill_err}), 32'd0);
                tick();
                tick();
                #2 sys_rst_n = 1'b1;
                tick();
                return;
            end
            if (poke && i == 2) wr_done = 1'b1;   // lands in SEND, must be ignored
            stab = 1'b1;
            for (int unsigned k = 1; k < lat; k++) begin
                tick();
                wr_done = 1'b0;
                start   = (poke && i == 3 && k == 1);
                if (fill_data !== exp_q[i] || en_write_fill !== 1'b0 ||
                    busy !== 1'b1 || fill_done !== 1'b0)
                    stab = 1'b0;
            end
            start = 1'b0;
            tick();
            wr_done = 1'b1;
            tick();
            wr_done = 1'b0;
            check("hold_in_wait", 32'(stab), 32'd1);
            if (errors != e0) begin
                recover();
                return;
            end
        end
        check("done_pulse", 32'({fill_done, fill_err, en_write_fill}), 32'b100);
        tick();
        check("post_idle", 32'({busy, fill_done, fill_err, en_write_fill}), 32'd0);
        if (errors != e0) recover();
    endtask

    int unsigned rsx, rsy, rex, rey;
    bit          quiet;

    initial begin
        // Reset state
        tick();
        tick();
        check("reset_outs", 32'({fill_data, en_write_fill, busy, fill_done, fill_err}), 32'd0);
        #2 sys_rst_n = 1'b1;
        tick();

        // start ignored while init_done is low; stray wr_done in IDLE ignored
        start_x = 9'd1; start_y = 9'd1; end_x = 9'd2; end_y = 9'd2;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wr_done = 1'b1;
        quiet   = 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
            tick();
            wr_done = 1'b0;
            if (en_write_fill !== 1'b0 || busy !== 1'b0 || fill_done !== 1'b0) quiet = 1'b0;
        end
        check("no_init_ignored", 32'(quiet), 32'd1);
        init_done = 1'b1;
        tick();

        // Two-pixel red stripe with offsets: 15 bytes
        do_fill(0, 0, 1, 0, 16'hF800, 5, 1'b0, -1);

        // Rejected requests
        do_fill(5, 0, 3, 0, 16'h1234, 5, 1'b0, -1);
        do_fill(0, 0, 0, H, 16'h1234, 5, 1'b0, -1);
        do_fill(0, 0, W, 0, 16'h1234, 5, 1'b0, -1);
        do_fill(0, 9, 0, 8, 16'h1234, 5, 1'b0, -1);

        // start and stray wr_done while busy
        do_fill(10, 20, 12, 21, 16'($urandom), 5, 1'b1, -1);

        // Boundary: single pixel in the last column/row
        do_fill(W - 1, H - 1, W - 1, H - 1, 16'hA5C3, 5, 1'b0, -1);

        // Randomised small rectangles, some spilling off the panel
        for (int r = 0; r < 8; r++) begin
            rsx = $urandom_range(0, W - 1);
            rsy = $urandom_range(0, H - 1);
            rex = rsx + $urandom_range(0, 3);
            rey = rsy + $urandom_range(0, 2);
            if ($urandom_range(0, 5) == 0) rex = (rsx > 0) ? rsx - 1 : rex;
            do_fill(rsx, rsy, rex, rey, 16'($urandom), $urandom_range(1, 6), 1'b0, -1);
        end

        // Reset during the pixel phase, then a fresh 1x1 fill
        do_fill(3, 3, 4, 4, 16'h5A5A, 5, 1'b0, 13);
        do_fill(5, 7, 5, 7, 16'h3C3C, 5, 1'b0, -1);

        // Full panel with the fastest byte engine
        do_fill(0, 0, W - 1, H - 1, 16'h07E0, 1, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
